uart_tx_arb: RTL

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_pkg.sv | 15 +
 rtl/rr_pick.sv | 43 ++++
 rtl/uart_tx_arb.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART transmitter arbiter: FSM state encoding and the
// requester index width.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ISSUE      = 2'd1,
    WAIT_START = 2'd2,
    WAIT_DONE  = 2'd3
  } uart_arb_state_t;

  // Index width covering the largest supported requester count (8).
  localparam int unsigned UART_IDX_W = 3;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first set request at ptr, ptr+1, ...
// wrapping modulo num_req wins.
module rr_pick
  import uart_pkg::*;
#(
  parameter int num_req = 4
) (
  input  logic [num_req-1:0]    req,
  input  logic [UART_IDX_W-1:0] ptr,
  output logic [num_req-1:0]    winner,
  output logic [UART_IDX_W-1:0] idx
);

  logic any_s;

  // Keep the request with the smallest rotating distance from ptr.
  always_comb begin
    int best_d;
    int d;
    logic take;
    best_d = num_req;
    d      = 0;
    take   = 1'b0;
    idx    = '0;
    any_s  = 1'b0;
    for (int i = 0; i < num_req; i++) begin
      d      = (i >= int'(ptr)) ? (i - int'(ptr)) : (i + num_req - int'(ptr));
      take   = req[i] && (d < best_d);
      best_d = take ? d : best_d;
      idx    = take ? UART_IDX_W'(i) : idx;
      any_s  = any_s | take;
    end
  end

  // One-hot view of the chosen index.
  always_comb begin
    winner = '0;
    for (int i = 0; i < num_req; i++) begin
      winner[i] = any_s && (idx == UART_IDX_W'(i));
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter feeding one UART transmitter from num_req requesters.
// Define UART_TX_ARB_LOCK_EN to keep a requester granted until req_last.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int num_req   = 4,
  parameter int data_bits = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [num_req-1:0]           req_vld,
  input  logic [num_req*data_bits-1:0] req_data,
  input  logic [num_req-1:0]           req_last,
  output logic [num_req-1:0]           req_rdy,
  output logic [data_bits-1:0]         tx_data_in,
  output logic                         tx_data_vld,
  input  logic                         tx_active,
  output logic [num_req-1:0]           grant,
  output logic                         busy
);

  uart_arb_state_t         state_r, state_nxt_s;
  logic [UART_IDX_W-1:0]   ptr_r, ptr_nxt_s, idx_s;
  logic [num_req-1:0]      grant_r, winner_s, pick_req_s, mask_s;
  logic [data_bits-1:0]    data_r, sel_data_s;
  logic                    tx_data_vld_r, sel_last_s, adv_s, accept_s;

  rr_pick #(.num_req(num_req)) u_rr_pick (
    .req    (pick_req_s),
    .ptr    (ptr_r),
    .winner (winner_s),
    .idx    (idx_s)
  );

  assign pick_req_s = req_vld & mask_s;
  // A grant is refused while reset is held so nothing is consumed unlatched.
  assign accept_s   = (state_r == IDLE) && !rst && (|pick_req_s);
  assign ptr_nxt_s  = (idx_s == UART_IDX_W'(num_req - 1)) ? '0 : (idx_s + UART_IDX_W'(1));

`ifdef UART_TX_ARB_LOCK_EN
  logic                  lock_r;
  logic [UART_IDX_W-1:0] owner_r;

  // While a packet is open only its owner may win.
  always_comb begin
    mask_s = '0;
    for (int i = 0; i < num_req; i++) begin
      mask_s[i] = !lock_r || (owner_r == UART_IDX_W'(i));
    end
  end

  assign adv_s = sel_last_s;

  // Packet lock: a character without req_last keeps the requester in possession.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_r  <= 1'b0;
      owner_r <= '0;
    end else if (accept_s) begin
      lock_r  <= !sel_last_s;
      owner_r <= idx_s;
    end
  end
`else
  logic unused_last_s;
  assign mask_s        = {num_req{1'b1}};
  assign adv_s         = 1'b1;
  assign unused_last_s = sel_last_s;
`endif

  // Steer the winning requester's character and last flag.
  always_comb begin
    sel_data_s = '0;
    sel_last_s = 1'b0;
    for (int i = 0; i < num_req; i++) begin
      sel_data_s = sel_data_s | (req_data[i*data_bits +: data_bits] & {data_bits{winner_s[i]}});
      sel_last_s = sel_last_s | (req_last[i] & winner_s[i]);
    end
  end

  // Next-state and accept strobe.
  always_comb begin
    state_nxt_s = state_r;
    req_rdy     = '0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          req_rdy     = winner_s;
          state_nxt_s = ISSUE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: state_nxt_s = WAIT_START;
      WAIT_START: begin
        if (tx_active) begin
          state_nxt_s = WAIT_DONE;
        end else begin
          state_nxt_s = WAIT_START;
        end
      end
      WAIT_DONE: begin
        if (!tx_active) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT_DONE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, pointer, grant and the held character.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      ptr_r         <= '0;
      grant_r       <= '0;
      data_r        <= '0;
      tx_data_vld_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      tx_data_vld_r <= accept_s;
      if (accept_s) begin
        grant_r <= winner_s;
        data_r  <= sel_data_s;
        if (adv_s) begin
          ptr_r <= ptr_nxt_s;
        end
      end else if ((state_r == WAIT_DONE) && !tx_active) begin
        grant_r <= '0;
      end
    end
  end

  assign grant       = grant_r;
  assign tx_data_in  = data_r;
  assign tx_data_vld = tx_data_vld_r;
  assign busy        = (state_r != IDLE);

endmodule
